// File: rtl/seq_multi_handler.sv
// seq_multi_handler: decodes command-bus frames into per-channel serial
// bit-pattern generators with one-shot, idle level and armed/sync start.
module seq_multi_handler #(
    parameter int         NUM_CH    = 8,
    parameter int         MAX_BITS  = 128,
    parameter int         DIV_W     = 16,
    parameter logic [7:0] CFG_TYPE  = 8'hF0,
    parameter logic [7:0] SYNC_TYPE = 8'hF1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        cmd_type,
    input  logic [15:0]       cmd_length,
    input  logic [7:0]        cmd_data,
    input  logic [15:0]       cmd_data_index,
    input  logic              cmd_start,
    input  logic              cmd_data_valid,
    input  logic              cmd_done,
    output logic              cmd_ready,
    output logic [NUM_CH-1:0] seq_pins,
    output logic [NUM_CH-1:0] seq_busy,
    output logic              cfg_err
);

    localparam int PAT_B    = MAX_BITS / 8;
    localparam int CFG_LEN  = 5 + PAT_B;
    localparam int SYNC_LEN = (NUM_CH + 7) / 8;
    localparam int SH_N     = (CFG_LEN > SYNC_LEN) ? CFG_LEN : SYNC_LEN;
    localparam int BIT_W    = $clog2(MAX_BITS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RX_CFG,
        S_RX_SYNC,
        S_COMMIT
    } state_t;

    state_t      r_state;
    logic        r_is_sync;
    logic [15:0] r_len;
    logic [7:0]  r_sh [SH_N];
    logic        r_ready;
    logic        r_err;

    logic [7:0]          w_ch;
    logic                w_en;
    logic                w_os;
    logic                w_idle;
    logic                w_armed;
    logic [DIV_W-1:0]    w_div;
    logic [7:0]          w_blen;
    logic [MAX_BITS-1:0] w_pat;
    logic [NUM_CH-1:0]   w_mask;
    logic                w_cfg_ok;
    logic                w_sync_ok;
    logic                w_ok;
    logic                w_commit;

    // Shadow byte layout of a CFG frame
    assign w_ch    = r_sh[0];
    assign w_en    = r_sh[1][0];
    assign w_os    = r_sh[1][1];
    assign w_idle  = r_sh[1][2];
    assign w_armed = r_sh[1][3];
    assign w_div   = DIV_W'({r_sh[2], r_sh[3]});
    assign w_blen  = r_sh[4];

    always_comb begin
        w_pat = '0;
        for (int b = 0; b < PAT_B; b++) begin
            w_pat[b*8 +: 8] = r_sh[5+b];
        end
    end

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_mask[i] = r_sh[i/8][i%8];
        end
    end

    assign w_cfg_ok  = (r_len == 16'(CFG_LEN))
                    && (int'(w_ch) < NUM_CH)
                    && (w_blen != 8'd0)
                    && (int'(w_blen) <= MAX_BITS)
                    && (w_div != '0);
    assign w_sync_ok = (r_len == 16'(SYNC_LEN));
    assign w_ok      = r_is_sync ? w_sync_ok : w_cfg_ok;
    assign w_commit  = (r_state == S_COMMIT);

    // Frame reception; a new start inside RX_* restarts the frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_is_sync <= 1'b0;
            r_len     <= '0;
            r_ready   <= 1'b1;
            r_err     <= 1'b0;
            for (int j = 0; j < SH_N; j++) begin
                r_sh[j] <= '0;
            end
        end else begin
            r_err <= 1'b0;
            if (r_state != S_COMMIT && cmd_start) begin
                r_len <= cmd_length;
                for (int j = 0; j < SH_N; j++) begin
                    r_sh[j] <= '0;
                end
                if (cmd_type == CFG_TYPE) begin
                    r_state   <= S_RX_CFG;
                    r_is_sync <= 1'b0;
                    r_ready   <= 1'b0;
                end else if (cmd_type == SYNC_TYPE) begin
                    r_state   <= S_RX_SYNC;
                    r_is_sync <= 1'b1;
                    r_ready   <= 1'b0;
                end else begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
            end else begin
                unique case (r_state)
                    S_RX_CFG, S_RX_SYNC: begin
                        if (cmd_data_valid) begin
                            for (int j = 0; j < SH_N; j++) begin
                                if (cmd_data_index == 16'(j)) begin
                                    r_sh[j] <= cmd_data;
                                end
                            end
                        end
                        if (cmd_done) begin
                            r_state <= S_COMMIT;
                        end
                    end
                    S_COMMIT: begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                        r_err   <= ~w_ok;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    logic [MAX_BITS-1:0] r_pat  [NUM_CH];
    logic [DIV_W-1:0]    r_div  [NUM_CH];
    logic [DIV_W-1:0]    r_cnt  [NUM_CH];
    logic [BIT_W-1:0]    r_last [NUM_CH];
    logic [BIT_W-1:0]    r_bit  [NUM_CH];
    logic [NUM_CH-1:0]   r_en;
    logic [NUM_CH-1:0]   r_os;
    logic [NUM_CH-1:0]   r_idle;
    logic [NUM_CH-1:0]   r_busy;
    logic [NUM_CH-1:0]   r_pin;

    // Pin is registered from the bit selected in the previous cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_en   <= '0;
            r_os   <= '0;
            r_idle <= '0;
            r_busy <= '0;
            r_pin  <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_pat[i]  <= '0;
                r_div[i]  <= '0;
                r_cnt[i]  <= '0;
                r_last[i] <= '0;
                r_bit[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_pin[i] <= r_busy[i] ? r_pat[i][r_bit[i]] : r_idle[i];
                if (w_commit && !r_is_sync && w_cfg_ok
                    && (w_ch == 8'(i))) begin
                    r_en[i]   <= w_en;
                    r_os[i]   <= w_os;
                    r_idle[i] <= w_idle;
                    r_div[i]  <= w_div;
                    r_last[i] <= BIT_W'(w_blen - 8'd1);
                    r_pat[i]  <= w_pat;
                    r_cnt[i]  <= '0;
                    r_bit[i]  <= '0;
                    r_busy[i] <= w_en & ~w_armed;
                end else if (w_commit && r_is_sync && w_sync_ok
                             && w_mask[i] && r_en[i]) begin
                    r_cnt[i]  <= '0;
                    r_bit[i]  <= '0;
                    r_busy[i] <= 1'b1;
                end else if (r_busy[i]) begin
                    if (r_cnt[i] == r_div[i] - 1'b1) begin
                        r_cnt[i] <= '0;
                        if (r_bit[i] == r_last[i]) begin
                            r_bit[i] <= '0;
                            if (r_os[i]) begin
                                r_busy[i] <= 1'b0;
                            end
                        end else begin
                            r_bit[i] <= r_bit[i] + 1'b1;
                        end
                    end else begin
                        r_cnt[i] <= r_cnt[i] + 1'b1;
                    end
                end
            end
        end
    end

    assign cmd_ready = r_ready;
    assign seq_pins  = r_pin;
    assign seq_busy  = r_busy;
    assign cfg_err   = r_err;

endmodule

// File: tb/tb_seq_multi_handler.sv
// Directed self-checking bench for seq_multi_handler.
// Inputs change 1ns after posedge; outputs sampled there too.
module tb_seq_multi_handler;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  cmd_type;
    logic [15:0] cmd_length;
    logic [7:0]  cmd_data;
    logic [15:0] cmd_data_index;
    logic        cmd_start;
    logic        cmd_data_valid;
    logic        cmd_done;
    logic        cmd_ready;
    logic [7:0]  seq_pins;
    logic [7:0]  seq_busy;
    logic        cfg_err;

    always #5 clk = ~clk;

    seq_multi_handler dut (
        .clk(clk),
        .rst(rst),
        .cmd_type(cmd_type),
        .cmd_length(cmd_length),
        .cmd_data(cmd_data),
        .cmd_data_index(cmd_data_index),
        .cmd_start(cmd_start),
        .cmd_data_valid(cmd_data_valid),
        .cmd_done(cmd_done),
        .cmd_ready(cmd_ready),
        .seq_pins(seq_pins),
        .seq_busy(seq_busy),
        .cfg_err(cfg_err)
    );

    logic [7:0]  fb [0:31];
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          t0 = 0;
    logic [9:0]  pat0 = 10'h155;
    logic [2:0]  pat1 = 3'b011;
    logic [15:0] pat2 = 16'hAAF0;
    logic [3:0]  pat3 = 4'hA;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic build_cfg(input logic [7:0] ch, input logic [7:0] mode,
                             input logic [15:0] dv, input logic [7:0] bl,
                             input logic [127:0] pat);
        fb[0] = ch;
        fb[1] = mode;
        fb[2] = dv[15:8];
        fb[3] = dv[7:0];
        fb[4] = bl;
        for (int b = 0; b < 16; b++) fb[5+b] = pat[b*8 +: 8];
    endtask

    // Returns 1ns after the edge that samples cmd_done
    task automatic send(input logic [7:0] typ, input logic [15:0] clen,
                        input int nb);
        int w;
        w = 0;
        while (!cmd_ready && w < 20) begin
            step();
            w++;
        end
        chk("rdy_pre", cmd_ready, 1);
        cmd_start  = 1'b1;
        cmd_type   = typ;
        cmd_length = clen;
        step();
        cmd_start = 1'b0;
        chk("rdy_low", cmd_ready, 0);
        for (int i = 0; i < nb; i++) begin
            cmd_data_valid = 1'b1;
            cmd_data       = fb[i];
            cmd_data_index = 16'(i);
            step();
        end
        cmd_data_valid = 1'b0;
        cmd_done       = 1'b1;
        step();
        cmd_done = 1'b0;
    endtask

    task automatic chk_ch0();
        int k;
        k = cyc - t0;
        chk("ch0_run", seq_pins[0], pat0[(k/4)%10]);
    endtask

    task automatic err_case(input string tag, input logic [15:0] clen,
                            input int nb);
        send(8'hF0, clen, nb);
        step();
        chk({tag, "_err"}, cfg_err, 1);
        chk_ch0();
        step();
        chk({tag, "_clr"}, cfg_err, 0);
        chk({tag, "_busy0"}, seq_busy[0], 1);
        chk_ch0();
        repeat (6) begin
            step();
            chk_ch0();
        end
    endtask

    initial begin
        rst            = 1'b1;
        cmd_type       = '0;
        cmd_length     = '0;
        cmd_data       = '0;
        cmd_data_index = '0;
        cmd_start      = 1'b0;
        cmd_data_valid = 1'b0;
        cmd_done       = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("rst_pins", seq_pins, 0);
        chk("rst_busy", seq_busy, 0);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_err", cfg_err, 0);
        rst = 1'b0;
        step();

        // Unknown type is ignored
        cmd_start = 1'b1;
        cmd_type  = 8'h42;
        step();
        cmd_start = 1'b0;
        chk("ign_ready", cmd_ready, 1);

        // ch0 continuous, div 4, len 10
        build_cfg(8'd0, 8'h01, 16'd4, 8'd10, 128'h155);
        send(8'hF0, 16'd21, 21);
        step();
        chk("c0_err", cfg_err, 0);
        chk("c0_busy", seq_busy[0], 1);
        chk("c0_ready", cmd_ready, 1);
        chk("c0_pre", seq_pins[0], 0);
        step();
        t0 = cyc;
        for (int i = 0; i < 50; i++) begin
            chk_ch0();
            step();
        end

        // ch1 one-shot, idle 1
        build_cfg(8'd1, 8'h07, 16'd2, 8'd3, 128'h3);
        send(8'hF0, 16'd21, 21);
        step();
        chk("c1_busy", seq_busy[1], 1);
        chk("c1_pre", seq_pins[1], 0);
        step();
        for (int k = 0; k < 10; k++) begin
            chk("c1_pin", seq_pins[1], (k < 6) ? pat1[k/2] : 1'b1);
            chk("c1_bsy", seq_busy[1], (k < 5) ? 1 : 0);
            chk_ch0();
            step();
        end

        // SYNC replays the one-shot
        fb[0] = 8'h02;
        send(8'hF1, 16'd1, 1);
        step();
        chk("s1_err", cfg_err, 0);
        chk("s1_busy", seq_busy[1], 1);
        step();
        for (int k = 0; k < 10; k++) begin
            chk("s1_pin", seq_pins[1], (k < 6) ? pat1[k/2] : 1'b1);
            chk("s1_bsy", seq_busy[1], (k < 5) ? 1 : 0);
            chk_ch0();
            step();
        end

        // Armed ch2/ch3 wait for SYNC
        build_cfg(8'd2, 8'h09, 16'd3, 8'd16, 128'hAAF0);
        send(8'hF0, 16'd21, 21);
        step();
        chk("a2_err", cfg_err, 0);
        step();
        build_cfg(8'd3, 8'h09, 16'd5, 8'd4, 128'hA);
        send(8'hF0, 16'd21, 21);
        step();
        step();
        chk("arm_pins", seq_pins[3:2], 0);
        chk("arm_busy", seq_busy[3:2], 0);
        fb[0] = 8'h0C;
        send(8'hF1, 16'd1, 1);
        step();
        chk("s23_busy", seq_busy[3:2], 2'b11);
        step();
        for (int k = 0; k < 30; k++) begin
            chk("s2_pin", seq_pins[2], pat2[(k/3)%16]);
            chk("s3_pin", seq_pins[3], pat3[(k/5)%4]);
            chk_ch0();
            step();
        end

        // Rejected frames leave ch0 alone
        build_cfg(8'd0, 8'h01, 16'd4, 8'd10, 128'h3FF);
        err_case("len13", 16'd13, 13);
        build_cfg(8'd8, 8'h01, 16'd4, 8'd10, 128'h3FF);
        err_case("ch8", 16'd21, 21);
        build_cfg(8'd0, 8'h01, 16'd0, 8'd10, 128'h3FF);
        err_case("div0", 16'd21, 21);
        build_cfg(8'd0, 8'h01, 16'd4, 8'd0, 128'h3FF);
        err_case("len0", 16'd21, 21);

        // Reconfigure running ch0
        build_cfg(8'd0, 8'h01, 16'd120, 8'd4, 128'hA);
        send(8'hF0, 16'd21, 21);
        step();
        chk("r0_err", cfg_err, 0);
        chk("r0_busy", seq_busy[0], 1);
        step();
        chk("r0_b0", seq_pins[0], 0);
        repeat (119) step();
        chk("r0_b0_end", seq_pins[0], 0);
        step();
        chk("r0_b1", seq_pins[0], 1);
        repeat (20) step();
        chk("pre_rst_pins", seq_pins[1:0], 2'b11);

        // Asynchronous reset mid-bit
        #2;
        rst = 1'b1;
        #1;
        chk("arst_pins", seq_pins, 0);
        chk("arst_busy", seq_busy, 0);
        chk("arst_ready", cmd_ready, 1);
        chk("arst_err", cfg_err, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        chk("post_pins", seq_pins, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
